// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller: interval/selector codes,
// default durations and the interval timer state type.
package traffic_pkg;

    localparam logic [1:0] INT_BASE    = 2'b00;
    localparam logic [1:0] INT_EXT     = 2'b01;
    localparam logic [1:0] INT_YEL     = 2'b10;
    localparam logic [1:0] INT_BASE_X2 = 2'b11;

    localparam logic [1:0] SEL_BASE     = 2'b00;
    localparam logic [1:0] SEL_EXT      = 2'b01;
    localparam logic [1:0] SEL_YEL      = 2'b10;
    localparam logic [1:0] SEL_DEFAULTS = 2'b11;

    localparam int unsigned T_BASE_DEF = 6;
    localparam int unsigned T_EXT_DEF  = 3;
    localparam int unsigned T_YEL_DEF  = 2;

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StExpire
    } timer_state_e;

endpackage

// File: rtl/interval_timer_if.sv
// Sequencer/programming handshake of the interval timer.
// time_left exists only when INTERVAL_TIMER_TIME_LEFT_EN is defined.
interface interval_timer_if #(
    parameter int unsigned VAL_W = 4,
    parameter int unsigned CNT_W = 5
);
    logic             start_timer;
    logic [1:0]       interval;
    logic             prog_sync;
    logic [1:0]       time_param_selector;
    logic [VAL_W-1:0] time_value;
    logic             expired;
    logic             one_hz_enable;
`ifdef INTERVAL_TIMER_TIME_LEFT_EN
    logic [CNT_W-1:0] time_left;

    modport master (
        output start_timer, interval, prog_sync, time_param_selector, time_value,
        input  expired, one_hz_enable, time_left
    );
    modport slave (
        input  start_timer, interval, prog_sync, time_param_selector, time_value,
        output expired, one_hz_enable, time_left
    );
`else
    modport master (
        output start_timer, interval, prog_sync, time_param_selector, time_value,
        input  expired, one_hz_enable
    );
    modport slave (
        input  start_timer, interval, prog_sync, time_param_selector, time_value,
        output expired, one_hz_enable
    );
`endif
endinterface

// File: rtl/interval_timer_tick_divider.sv
// Prescaler: counts 0..TICK_DIV-1 and pulses tick_o on the wrap.
// A synchronous clear restarts the second and suppresses a coincident wrap pulse.
module tick_divider #(
    parameter int unsigned TICK_DIV = 100000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wrap;

    always_comb begin
        wrap   = (cnt_q == CntLast);
        cnt_d  = (clr_i || wrap) ? '0 : cnt_q + CntW'(1);
        tick_o = wrap & ~clr_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/interval_timer.sv
// Programmable countdown timer with a 1 s prescaler and one-cycle expiry pulse.
// Optional time_left output under INTERVAL_TIMER_TIME_LEFT_EN.
module interval_timer
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned VAL_W    = 4,
    parameter int unsigned CNT_W    = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    interval_timer_if.slave bus_io
);

    timer_state_e     state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [VAL_W-1:0] t_base_q, t_base_d;
    logic [VAL_W-1:0] t_ext_q, t_ext_d;
    logic [VAL_W-1:0] t_yel_q, t_yel_d;
    logic [VAL_W-1:0] wr_val;
    logic [CNT_W-1:0] load_val;
    logic             one_hz_q;
    logic             tick;

    tick_divider #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_divider (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (bus_io.start_timer),
        .tick_o(tick)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            count_q  <= '0;
            t_base_q <= VAL_W'(T_BASE_DEF);
            t_ext_q  <= VAL_W'(T_EXT_DEF);
            t_yel_q  <= VAL_W'(T_YEL_DEF);
            one_hz_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            t_base_q <= t_base_d;
            t_ext_q  <= t_ext_d;
            t_yel_q  <= t_yel_d;
            one_hz_q <= tick;
        end
    end

    always_comb begin
        t_base_d = t_base_q;
        t_ext_d  = t_ext_q;
        t_yel_d  = t_yel_q;
        wr_val   = (bus_io.time_value == '0) ? VAL_W'(1) : bus_io.time_value;
        if (bus_io.prog_sync) begin
            case (bus_io.time_param_selector)
                SEL_BASE: t_base_d = wr_val;
                SEL_EXT:  t_ext_d  = wr_val;
                SEL_YEL:  t_yel_d  = wr_val;
                default: begin
                    t_base_d = VAL_W'(T_BASE_DEF);
                    t_ext_d  = VAL_W'(T_EXT_DEF);
                    t_yel_d  = VAL_W'(T_YEL_DEF);
                end
            endcase
        end

        // Loads read the _d copies so a same-cycle write is bypassed into the count.
        case (bus_io.interval)
            INT_BASE: load_val = CNT_W'(t_base_d);
            INT_EXT:  load_val = CNT_W'(t_ext_d);
            INT_YEL:  load_val = CNT_W'(t_yel_d);
            default:  load_val = CNT_W'(t_base_d) << 1;
        endcase

        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.start_timer) begin
                    state_d = StCount;
                    count_d = load_val;
                end
            end
            StCount: begin
                if (bus_io.start_timer) begin
                    count_d = load_val;
                end else if (bus_io.prog_sync) begin
                    state_d = StIdle;
                    count_d = '0;
                end else if (tick) begin
                    if (count_q == CNT_W'(1)) begin
                        state_d = StExpire;
                        count_d = '0;
                    end else begin
                        count_d = count_q - CNT_W'(1);
                    end
                end
            end
            StExpire: begin
                if (bus_io.start_timer) begin
                    state_d = StCount;
                    count_d = load_val;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                count_d = '0;
            end
        endcase
    end

    always_comb begin
        bus_io.expired       = (state_q == StExpire);
        bus_io.one_hz_enable = one_hz_q;
`ifdef INTERVAL_TIMER_TIME_LEFT_EN
        bus_io.time_left     = count_q;
`endif
    end

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: directed scenarios plus random traffic,
// every cycle compared against a deadline-based reference model.
module tb_interval_timer;

    localparam int unsigned TD = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    interval_timer_if #(.VAL_W(4), .CNT_W(5)) tif ();

    interval_timer #(
        .TICK_DIV(TD),
        .VAL_W   (4),
        .CNT_W   (5)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus_io(tif)
    );

    // Reference model: programmed durations, absolute edge of the pending expiry
    // (-1 when none) and edge of the last prescaler restart.
    int unsigned dur[3];
    int          edge_n;
    int          base_edge;
    int          deadline;
    int          errors = 0;
    int          checks = 0;

    function automatic int load_secs(input logic [1:0] iv);
        case (iv)
            2'b00:   return int'(dur[0]);
            2'b01:   return int'(dur[1]);
            2'b10:   return int'(dur[2]);
            default: return 2 * int'(dur[0]);
        endcase
    endfunction

    task automatic model_reset();
        dur[0]    = 6;
        dur[1]    = 3;
        dur[2]    = 2;
        edge_n    = 0;
        base_edge = 0;
        deadline  = -1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic check_outputs(input logic exp_pulse, input logic exp_hz, input int exp_left);
        chk("expired", 32'(tif.expired), 32'(exp_pulse));
        chk("one_hz_enable", 32'(tif.one_hz_enable), 32'(exp_hz));
`ifdef INTERVAL_TIMER_TIME_LEFT_EN
        chk("time_left", 32'(tif.time_left), 32'(exp_left));
`else
        if (exp_left < 0) $display("note: negative remaining time in model");
`endif
    endtask

    task automatic step(input logic st, input logic [1:0] iv, input logic pg,
                        input logic [1:0] sel, input logic [3:0] val);
        logic exp_pulse;
        logic exp_hz;
        int   exp_left;
        tif.start_timer         = st;
        tif.interval            = iv;
        tif.prog_sync           = pg;
        tif.time_param_selector = sel;
        tif.time_value          = val;
        @(posedge clk);
        edge_n++;
        if (pg) begin
            if (sel == 2'b11) begin
                dur[0] = 6;
                dur[1] = 3;
                dur[2] = 2;
            end else begin
                dur[sel] = (val == 4'd0) ? 1 : int'(val);
            end
        end
        exp_pulse = (deadline == edge_n) && !st && !pg;
        if (st) begin
            deadline  = edge_n + int'(TD) * load_secs(iv);
            base_edge = edge_n;
        end else if (pg || exp_pulse) begin
            deadline = -1;
        end
        exp_hz   = (edge_n > base_edge) && (((edge_n - base_edge) % int'(TD)) == 0);
        exp_left = (deadline < 0) ? 0 : (deadline - edge_n + int'(TD) - 1) / int'(TD);
        #1;
        check_outputs(exp_pulse, exp_hz, exp_left);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, 2'b00, 4'd0);
    endtask

    // Latency counted in edges from the start edge to the edge after which expired is high.
    task automatic expect_latency(input int n, input string tag);
        int   c;
        logic seen;
        c    = 0;
        seen = 1'b0;
        while (!seen && c < n + 8) begin
            step(1'b0, 2'b00, 1'b0, 2'b00, 4'd0);
            c++;
            if (tif.expired === 1'b1) seen = 1'b1;
        end
        chk(tag, 32'(c), 32'(n));
    endtask

    initial begin
        rst                     = 1'b1;
        tif.start_timer         = 1'b0;
        tif.interval            = 2'b00;
        tif.prog_sync           = 1'b0;
        tif.time_param_selector = 2'b00;
        tif.time_value          = 4'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs(1'b0, 1'b0, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // tBASE default
        step(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
        expect_latency(24, "lat_base");
        idle(10);

        // doubled base
        step(1'b1, 2'b11, 1'b0, 2'b00, 4'd0);
        expect_latency(48, "lat_base_x2");
        idle(3);

        // zero written to tYEL clamps to 1 s
        step(1'b0, 2'b00, 1'b1, 2'b10, 4'd0);
        step(1'b1, 2'b10, 1'b0, 2'b00, 4'd0);
        expect_latency(4, "lat_yel_clamp");
        idle(2);

        // write bypass into a coincident start, then restore defaults
        step(1'b1, 2'b00, 1'b1, 2'b00, 4'd9);
        expect_latency(36, "lat_bypass");
        step(1'b0, 2'b00, 1'b1, 2'b11, 4'd15);
        step(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
        expect_latency(24, "lat_defaults");
        idle(2);

        // restart on the final tick suppresses the pulse
        step(1'b1, 2'b01, 1'b0, 2'b00, 4'd0);
        idle(11);
        step(1'b1, 2'b01, 1'b0, 2'b00, 4'd0);
        expect_latency(12, "lat_restart");
        idle(2);

        // abort by programming mid-count
        step(1'b1, 2'b01, 1'b0, 2'b00, 4'd0);
        idle(5);
        step(1'b0, 2'b00, 1'b1, 2'b01, 4'd5);
        idle(30);

        // asynchronous reset mid-count, on a one_hz_enable cycle
        step(1'b0, 2'b00, 1'b1, 2'b00, 4'd11);
        step(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
        idle(8);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs(1'b0, 1'b0, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        step(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
        expect_latency(24, "lat_after_reset");

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0, 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)));
        end
        idle(130);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/interval_timer.md
# interval_timer

Programmable countdown timer that the traffic-light sequencer drives through its `interval` / `start_timer` / `expired` handshake. It holds the three run-time duration registers (tBASE, tEXT, tYEL) and lets the programming inputs rewrite them. It derives a 1 s tick from `clk` and returns a single-cycle `expired` pulse when the selected interval has elapsed. It sits between the sequencer FSM and the synchronised programming switches.

## Interface
- `TICK_DIV`, 100000000: `clk` cycles per 1 s tick (≥2).
- `VAL_W`, 4: width of one programmable duration, in seconds.
- `CNT_W`, 5: countdown width; must hold 2×(2^VAL_W−1).
- `clk`  in  1  system clock.
- `Reset_Sync`  in  1  asynchronous, active-high reset.
- `start_timer`  in  1  load the selected interval and begin counting.
- `interval`  in  2  interval select: 00 tBASE, 01 tEXT, 10 tYEL, 11 2×tBASE.
- `Prog_Sync`  in  1  write `Time_Value` to the parameter chosen by `Time_Param_Selector`.
- `Time_Param_Selector`  in  2  00 tBASE, 01 tEXT, 10 tYEL, 11 restore all defaults.
- `Time_Value`  in  VAL_W  new duration, in seconds.
- `expired`  out  1  one-cycle pulse when the countdown reaches 0.
- `one_hz_enable`  out  1  one-cycle pulse on every prescaler wrap; free-running.
- `time_left`  out  CNT_W  remaining seconds. Present only with the config macro.

## Operation
- Reset values:
  - tBASE=6, tEXT=3, tYEL=2.
  - State IDLE.
  - Count 0, prescaler 0.
  - `expired`=0, `one_hz_enable`=0, `time_left`=0.
- Duration registers:
  - On `Prog_Sync`, write `Time_Value` to the selected register.
  - Selector 11 restores all three defaults and ignores `Time_Value`.
  - A written value of 0 is stored as 1, so the minimum duration is 1 s.
- Load value by `interval`: tBASE, tEXT, tYEL, or tBASE<<1. The doubling is zero-extended to CNT_W, with no overflow.
- FSM states:
  - IDLE: `start_timer` → COUNT.
  - COUNT:
    - On a tick with count==1 → EXPIRE.
    - On a tick otherwise, decrement.
    - `start_timer` → reload and stay in COUNT.
    - `Prog_Sync` → IDLE (abort, no pulse).
  - EXPIRE: `expired`=1 for this one cycle, then IDLE. `start_timer` in this cycle → COUNT with the new load.
- Priority within one cycle: `Prog_Sync` register write > `start_timer` > tick.
  - If `Prog_Sync` and `start_timer` coincide, the start loads the newly written value (write bypass) and COUNT is entered.
  - If `start_timer` coincides with the final tick, the restart wins and no `expired` pulse is produced.
- Prescaler:
  - Counts 0..TICK_DIV−1 and wraps; the tick is asserted on the wrap.
  - Every `start_timer` clears the prescaler to 0, so each second is a full TICK_DIV cycles.

## Timing
- `start_timer` is sampled at edge k. Ticks then occur at edges k+TICK_DIV·i.
- `expired` is high in the cycle following edge k+N·TICK_DIV, where N is the loaded count. Exact latency is N·TICK_DIV cycles.
- `expired` and `one_hz_enable` are registered outputs, each exactly one cycle wide.
- `time_left` is registered. It shows the load value in the cycle after the start edge and updates in the cycle after each tick.
- A `Prog_Sync` write is visible to a load in the same cycle (bypass) and to all later loads.
- `Reset_Sync` asserted mid-count:
  - All state returns to reset values immediately, without waiting for a clock edge.
  - No `expired` pulse is produced.
  - Programmed values are lost.

## Configuration
- `INTERVAL_TIMER_TIME_LEFT_EN`:
  - Defined: the `time_left` port exists and is driven as in Timing.
  - Undefined: the port is absent and its register is removed.
  - Countdown and `expired` behaviour is identical either way.

## Structure
- Shared package `traffic_pkg` holds:
  - Interval codes: `INT_BASE`=2'b00, `INT_EXT`=2'b01, `INT_YEL`=2'b10, `INT_BASE_X2`=2'b11.
  - Selector codes, including `SEL_DEFAULTS`=2'b11.
  - Default durations `T_BASE_DEF`=6, `T_EXT_DEF`=3, `T_YEL_DEF`=2.
  - The timer state enum.
- One sub-module, `tick_divider`: the prescaler, with a synchronous clear input and a wrap-pulse output.

## Test plan
All scenarios use TICK_DIV=4.
- Reset, then start with `interval`=00 → `expired` pulses once, exactly 24 cycles after the start edge, and stays 0 afterwards.
- Start with `interval`=11 → `expired` pulses after 48 cycles. With the macro defined, `time_left` steps 12,11,…,1.
- `Prog_Sync`, selector 10, `Time_Value`=0, then start with `interval`=10 → `expired` after 4 cycles (value clamped to 1).
- `Prog_Sync`, selector 00, `Time_Value`=9, in the same cycle as start with `interval`=00 → `expired` after 36 cycles. A following `Prog_Sync` with selector 11, then start with `interval`=00 → `expired` after 24 cycles.
- Start with `interval`=01, then a second start with `interval`=01 in the cycle of the final tick → no pulse at 12 cycles; `expired` 12 cycles after the second start.
- Assert `Reset_Sync` between clock edges mid-count → outputs are 0 before the next edge, with no `expired` pulse. After release, tBASE=6 again.
